// File: rtl/iiitb_alu.sv
// Registered 8-operation ALU: A/B/op sampled on each rising edge, R/carry/zero
// presented one cycle later. Synchronous active-high reset.
module iiitb_alu #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       op,
    output logic [WIDTH-1:0] R,
    output logic             carry,
    output logic             zero
);

    localparam int unsigned XW = WIDTH + 1;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_AND = 3'd2,
        OP_OR  = 3'd3,
        OP_XOR = 3'd4,
        OP_NOT = 3'd5,
        OP_SHL = 3'd6,
        OP_SHR = 3'd7
    } op_e;

    logic [XW-1:0]    sum_c;
    logic [XW-1:0]    diff_c;
    logic [WIDTH-1:0] res_c;
    logic             carry_c;

    // Extended-width add/sub so the top bit is the carry or borrow out
    assign sum_c  = XW'(A) + XW'(B);
    assign diff_c = XW'(A) - XW'(B);

    // Next result and flag, fully decoded for every opcode
    always_comb begin
        res_c   = '0;
        carry_c = 1'b0;
        unique case (op_e'(op))
            OP_ADD: begin
                res_c   = sum_c[WIDTH-1:0];
                carry_c = sum_c[WIDTH];
            end
            OP_SUB: begin
                res_c   = diff_c[WIDTH-1:0];
                carry_c = diff_c[WIDTH];
            end
            OP_AND: res_c = A & B;
            OP_OR:  res_c = A | B;
            OP_XOR: res_c = A ^ B;
            OP_NOT: res_c = ~A;
            OP_SHL: begin
                res_c   = {A[WIDTH-2:0], 1'b0};
                carry_c = A[WIDTH-1];
            end
            OP_SHR: begin
                res_c   = {1'b0, A[WIDTH-1:1]};
                carry_c = A[0];
            end
            default: begin
                res_c   = '0;
                carry_c = 1'b0;
            end
        endcase
    end

    // zero follows the new result, not the previously held one
    always_ff @(posedge clk) begin
        if (rst) begin
            R     <= '0;
            carry <= 1'b0;
            zero  <= 1'b1;
        end else begin
            R     <= res_c;
            carry <= carry_c;
            zero  <= (res_c == '0);
        end
    end

endmodule

// File: tb/tb_iiitb_alu.sv
// Scoreboard bench for iiitb_alu: stimulus pushes expected results from an
// arithmetic reference model; a monitor pops and compares one cycle later.
module tb_iiitb_alu;

    logic       clk;
    logic       rst;
    logic [7:0] A;
    logic [7:0] B;
    logic [2:0] op;
    logic [7:0] R;
    logic       carry;
    logic       zero;

    iiitb_alu #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst   (rst),
        .A     (A),
        .B     (B),
        .op    (op),
        .R     (R),
        .carry (carry),
        .zero  (zero)
    );

    typedef struct {
        logic [7:0] r;
        logic       c;
        logic       z;
        string      tag;
    } exp_t;

    exp_t q[$];
    exp_t last_exp;
    int   n_cmp = 0;
    int   n_bad = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model in plain integer arithmetic
    function automatic exp_t model(input int a, input int b, input int o,
                                   input bit r, input string tag);
        exp_t e;
        int   rv;
        int   cv;
        rv = 0;
        cv = 0;
        if (r) begin
            rv = 0;
            cv = 0;
        end else begin
            case (o)
                0: begin rv = (a + b) % 256; cv = (a + b > 255) ? 1 : 0; end
                1: begin rv = (a - b + 256) % 256; cv = (a < b) ? 1 : 0; end
                2: rv = a & b;
                3: rv = a | b;
                4: rv = a ^ b;
                5: rv = 255 - a;
                6: begin rv = (a * 2) % 256; cv = (a >= 128) ? 1 : 0; end
                default: begin rv = a / 2; cv = a % 2; end
            endcase
        end
        e.r   = 8'(rv);
        e.c   = (cv != 0);
        e.z   = (rv == 0);
        e.tag = tag;
        return e;
    endfunction

    task automatic drive(input int a, input int b, input int o, input bit r,
                         input string tag);
        rst = r;
        A   = 8'(a);
        B   = 8'(b);
        op  = 3'(o);
        q.push_back(model(a, b, o, r, tag));
    endtask

    task automatic issue(input int a, input int b, input int o, input bit r,
                         input string tag);
        @(negedge clk);
        drive(a, b, o, r, tag);
    endtask

    task automatic check(input string tag, input exp_t e);
        n_cmp++;
        if (R !== e.r || carry !== e.c || zero !== e.z) begin
            n_bad++;
            $display("FAIL %s: got R=%02h carry=%b zero=%b, want R=%02h carry=%b zero=%b",
                     tag, R, carry, zero, e.r, e.c, e.z);
        end
    endtask

    // Monitor: every edge with an outstanding issue presents its result
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                last_exp = q.pop_front();
                check(last_exp.tag, last_exp);
            end
        end
    end

    initial begin
        rst = 1'b1;
        A   = 8'h00;
        B   = 8'h00;
        op  = 3'd0;

        issue(0, 0, 0, 1'b1, "reset_state");
        issue(8'hFF, 8'h01, 0, 1'b1, "reset_state2");

        for (int o = 0; o < 8; o++)
            issue(8'h6A, 8'h3B, o, 1'b0, $sformatf("vec_op%0d", o));

        issue(8'hFF, 8'h01, 0, 1'b0, "add_wrap");
        issue(8'h10, 8'h20, 1, 1'b0, "sub_borrow");
        issue(8'h20, 8'h20, 1, 1'b0, "sub_zero");
        issue(8'h81, 8'h00, 6, 1'b0, "shl_81");
        issue(8'h81, 8'h00, 7, 1'b0, "shr_81");
        issue(8'h00, 8'hFF, 5, 1'b0, "not_ff");
        issue(8'hFF, 8'h00, 5, 1'b0, "not_zero");
        issue(8'h55, 8'hAA, 2, 1'b0, "and_zero");

        issue(8'h12, 8'h34, 0, 1'b0, "pre_reset");
        issue(8'hFF, 8'h01, 0, 1'b1, "mid_reset");
        issue(8'hFF, 8'h01, 0, 1'b0, "post_reset_add");

        // Inputs changed mid-cycle must not disturb the held outputs
        issue(8'h6A, 8'h3B, 0, 1'b0, "hold_issue");
        @(posedge clk);
        #2;
        drive(8'h00, 8'h00, 1, 1'b0, "hold_next");
        #2;
        check("hold_mid_cycle", last_exp);
        @(posedge clk);

        for (int i = 0; i < 300; i++) begin
            bit r;
            r = ($urandom_range(0, 19) == 0);
            issue($urandom_range(0, 255), $urandom_range(0, 255),
                  $urandom_range(0, 7), r, $sformatf("rand%0d", i));
        end

        for (int k = 0; k < 10 && q.size() > 0; k++)
            @(posedge clk);
        #2;
        n_cmp++;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d outstanding, want 0", q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "timeout");
    end

endmodule
